// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: register map, FSM states
// and STATUS bit positions.
package uart_pkg;

  localparam logic [1:0] UART_REG_DATA    = 2'd0;
  localparam logic [1:0] UART_REG_STATUS  = 2'd1;
  localparam logic [1:0] UART_REG_DIVISOR = 2'd2;
  localparam logic [1:0] UART_REG_CTRL    = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_tx_state_t;

  localparam int STATUS_EMPTY_BIT = 0;
  localparam int STATUS_FULL_BIT  = 1;
  localparam int STATUS_BUSY_BIT  = 2;
  localparam int STATUS_LEVEL_LSB = 8;

endpackage

// File: rtl/uart_sync_fifo.sv
// Generic single-clock FIFO; extra pointer MSB separates full from empty.
// Full is judged before any same-cycle pop.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             push_ok, pop_ok;

  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign level_o = wr_ptr_q - rd_ptr_q;
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter with a Wishbone slave port and runtime baud divisor.
// Define UART_TX_PARITY_EN to build the parity stage and CTRL bits 8/9.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DAT_WIDTH   = 64,
  parameter int DATA_BITS   = 8,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 16,
  parameter int DEFAULT_DIV = 868
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 wb_stb_i,
  input  logic                 wb_we_i,
  input  logic [1:0]           wb_adr_i,
  input  logic [DAT_WIDTH-1:0] wb_dat_i,
  output logic [DAT_WIDTH-1:0] wb_dat_o,
  output logic                 wb_ack_o,
  output logic                 wb_err_o,
  output logic                 tx_o,
  output logic                 irq_o
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic                 ack_q, err_q, irq_q, tx_q, tx_d;
  logic [DAT_WIDTH-1:0] dat_q, rdata;
  logic [15:0]          divisor_q;
  logic [7:0]           thresh_q;
  logic                 par_en_cfg, par_odd_cfg;

  logic                 req, reg_wr, data_wr, fifo_push, fifo_pop;
  logic                 fifo_full, fifo_empty;
  logic [LW-1:0]        fifo_level;
  logic [DATA_BITS-1:0] fifo_rd_data;

  uart_tx_state_t       state_q, state_d;
  logic [15:0]          cnt_q, cnt_d, div_q, div_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 frame_par_en_q, frame_par_en_d, par_bit_q, par_bit_d;
  logic                 tick, start_frame;

  logic                 unused_bits;
  assign unused_bits = ^{wb_dat_i[DAT_WIDTH-1:16], wb_dat_i[9:8]};

  // A request is taken only while no response pulse is outstanding.
  assign req       = wb_stb_i && !ack_q && !err_q;
  assign reg_wr    = req && wb_we_i;
  assign data_wr   = reg_wr && (wb_adr_i == UART_REG_DATA);
  assign fifo_push = data_wr && !fifo_full;

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (fifo_push),
    .data_i  (wb_dat_i[DATA_BITS-1:0]),
    .pop_i   (fifo_pop),
    .data_o  (fifo_rd_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

`ifdef UART_TX_PARITY_EN
  logic par_en_q, par_odd_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
    end else if (reg_wr && wb_adr_i == UART_REG_CTRL) begin
      par_en_q  <= wb_dat_i[8];
      par_odd_q <= wb_dat_i[9];
    end
  end

  assign par_en_cfg  = par_en_q;
  assign par_odd_cfg = par_odd_q;
`else
  assign par_en_cfg  = 1'b0;
  assign par_odd_cfg = 1'b0;
`endif

  always_comb begin
    rdata = '0;
    case (wb_adr_i)
      UART_REG_STATUS: begin
        rdata[STATUS_EMPTY_BIT]               = fifo_empty;
        rdata[STATUS_FULL_BIT]                = fifo_full;
        rdata[STATUS_BUSY_BIT]                = (state_q != ST_IDLE);
        rdata[STATUS_LEVEL_LSB +: LW]         = fifo_level;
      end
      UART_REG_DIVISOR: rdata[15:0] = divisor_q;
      UART_REG_CTRL: begin
        rdata[7:0] = thresh_q;
        rdata[8]   = par_en_cfg;
        rdata[9]   = par_odd_cfg;
      end
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      dat_q     <= '0;
      divisor_q <= 16'(DEFAULT_DIV);
      thresh_q  <= 8'd0;
      irq_q     <= 1'b1;
    end else begin
      ack_q <= req && !(data_wr && fifo_full);
      err_q <= data_wr && fifo_full;
      dat_q <= (req && !wb_we_i) ? rdata : '0;
      irq_q <= (8'(fifo_level) <= thresh_q);
      if (reg_wr && wb_adr_i == UART_REG_DIVISOR) begin
        divisor_q <= (wb_dat_i[15:0] == 16'd0) ? 16'd1 : wb_dat_i[15:0];
      end
      if (reg_wr && wb_adr_i == UART_REG_CTRL) begin
        thresh_q <= wb_dat_i[7:0];
      end
    end
  end

  assign tick = (cnt_q == div_q - 16'd1);

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    div_d          = div_q;
    bit_cnt_d      = bit_cnt_q;
    stop_cnt_d     = stop_cnt_q;
    shift_d        = shift_q;
    frame_par_en_d = frame_par_en_q;
    par_bit_d      = par_bit_q;
    start_frame    = 1'b0;
    fifo_pop       = 1'b0;
    tx_d           = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) start_frame = 1'b1;
      end
      ST_START: begin
        tx_d = 1'b0;
        if (tick) begin
          state_d   = ST_DATA;
          bit_cnt_d = 3'd0;
        end
      end
      ST_DATA: begin
        tx_d = shift_q[0];
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
            state_d    = frame_par_en_q ? ST_PARITY : ST_STOP;
            stop_cnt_d = 1'b0;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        tx_d = par_bit_q;
        if (tick) begin
          state_d    = ST_STOP;
          stop_cnt_d = 1'b0;
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
            if (!fifo_empty) start_frame = 1'b1;
            else             state_d     = ST_IDLE;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_q != ST_IDLE) begin
      cnt_d = tick ? 16'd0 : cnt_q + 16'd1;
    end

    // Divisor and parity mode are sampled here so that mid-frame register
    // writes only affect the following frame.
    if (start_frame) begin
      fifo_pop       = 1'b1;
      state_d        = ST_START;
      cnt_d          = 16'd0;
      div_d          = divisor_q;
      shift_d        = fifo_rd_data;
      frame_par_en_d = par_en_cfg;
      par_bit_d      = (^fifo_rd_data) ^ par_odd_cfg;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= ST_IDLE;
      cnt_q          <= 16'd0;
      div_q          <= 16'(DEFAULT_DIV);
      bit_cnt_q      <= 3'd0;
      stop_cnt_q     <= 1'b0;
      shift_q        <= '0;
      frame_par_en_q <= 1'b0;
      par_bit_q      <= 1'b0;
      tx_q           <= 1'b1;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      div_q          <= div_d;
      bit_cnt_q      <= bit_cnt_d;
      stop_cnt_q     <= stop_cnt_d;
      shift_q        <= shift_d;
      frame_par_en_q <= frame_par_en_d;
      par_bit_q      <= par_bit_d;
      tx_q           <= tx_d;
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_err_o = err_q;
  assign wb_dat_o = dat_q;
  assign tx_o     = tx_q;
  assign irq_o    = irq_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: expected frames are queued on each DATA
// write and a serial monitor checks every cycle of each frame on tx_o.
module tb_uart_tx_fifo;
  import uart_pkg::*;

  localparam int DW = 64;
  localparam int DB = 8;
  localparam int SB = 1;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR_IMPL = 1'b1;
`else
  localparam bit PAR_IMPL = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          wb_stb_i = 1'b0;
  logic          wb_we_i = 1'b0;
  logic [1:0]    wb_adr_i = 2'd0;
  logic [DW-1:0] wb_dat_i = '0;
  logic [DW-1:0] wb_dat_o;
  logic          wb_ack_o, wb_err_o, tx_o, irq_o;

  uart_tx_fifo dut (
    .clk_i    (clk),
    .rst_ni   (rst_ni),
    .wb_stb_i (wb_stb_i),
    .wb_we_i  (wb_we_i),
    .wb_adr_i (wb_adr_i),
    .wb_dat_i (wb_dat_i),
    .wb_dat_o (wb_dat_o),
    .wb_ack_o (wb_ack_o),
    .wb_err_o (wb_err_o),
    .tx_o     (tx_o),
    .irq_o    (irq_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         div;
    bit         par_en;
    logic       par_bit;
  } frame_t;

  frame_t exp_q[$];
  int     starts[$];
  int     n_cmp = 0;
  int     n_fail = 0;
  int     cyc = 0;
  bit     mon_active = 1'b0;
  int     div_cur = 868;
  bit     par_en_cur = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Serial monitor: one comparison per completed frame, every cycle checked.
  initial begin : monitor
    frame_t     e;
    int         nbits, total, bad, b;
    logic [7:0] obs;
    logic       eb;
    bit         aborted;
    forever begin
      @(negedge clk);
      if (rst_ni !== 1'b1 || tx_o !== 1'b0) continue;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_frame: start bit seen at cycle %0d, required no frame", cyc);
        for (int w = 0; w < 1000 && tx_o === 1'b0; w++) @(negedge clk);
        continue;
      end
      e = exp_q.pop_front();
      mon_active = 1'b1;
      starts.push_back(cyc);
      nbits   = 1 + DB + (e.par_en ? 1 : 0) + SB;
      total   = nbits * e.div;
      bad     = 0;
      obs     = 8'h00;
      aborted = 1'b0;
      for (int k = 0; k < total; k++) begin
        if (k > 0) @(negedge clk);
        if (rst_ni !== 1'b1) begin
          aborted = 1'b1;
          break;
        end
        b = k / e.div;
        if (b == 0)                          eb = 1'b0;
        else if (b <= DB)                    eb = e.data[b-1];
        else if (e.par_en && b == DB + 1)    eb = e.par_bit;
        else                                 eb = 1'b1;
        if (tx_o !== eb) bad++;
        if (b >= 1 && b <= DB && (k % e.div) == e.div / 2) obs[b-1] = tx_o;
      end
      if (!aborted) begin
        n_cmp++;
        if (bad != 0 || obs !== e.data) begin
          n_fail++;
          $display("FAIL frame: got 0x%02h with %0d wrong bit-cycles, required 0x%02h with 0 (div %0d)",
                   obs, bad, e.data, e.div);
        end else begin
          $display("frame 0x%02h div %0d parity %0b ok", e.data, e.div, e.par_en);
        end
      end
      mon_active = 1'b0;
    end
  end

  task automatic wb_access(input logic we, input logic [1:0] adr, input logic [DW-1:0] wdata,
                           output logic ack, output logic err, output logic [DW-1:0] rdata);
    @(negedge clk);
    wb_stb_i = 1'b1;
    wb_we_i  = we;
    wb_adr_i = adr;
    wb_dat_i = wdata;
    ack = 1'b0;
    err = 1'b0;
    rdata = '0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (wb_ack_o === 1'b1 || wb_err_o === 1'b1) begin
        ack   = wb_ack_o;
        err   = wb_err_o;
        rdata = wb_dat_o;
        break;
      end
    end
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
    $display("wb %s adr %0d wdata 0x%0h -> ack %0b err %0b rdata 0x%0h",
             we ? "WR" : "RD", adr, wdata, ack, err, rdata);
  endtask

  task automatic push_byte(input logic [7:0] d, input bit accept, input logic pbit,
                           output logic ack, output logic err);
    frame_t        e;
    logic [DW-1:0] rd;
    if (accept) begin
      e.data    = d;
      e.div     = div_cur;
      e.par_en  = par_en_cur;
      e.par_bit = pbit;
      exp_q.push_back(e);
    end
    wb_access(1'b1, UART_REG_DATA, {56'd0, d}, ack, err, rd);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || mon_active || tx_o !== 1'b1) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_timeout: transmitter still active after %0d cycles, required idle", tag, budget);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_ni = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    div_cur    = 868;
    par_en_cur = 1'b0;
  endtask

  task automatic test_reset();
    logic ack, err;
    logic [DW-1:0] rd;
    rst_ni = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({tx_o, wb_ack_o, wb_err_o, irq_o} !== 4'b1001 || wb_dat_o !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: tx/ack/err/irq %b dat 0x%0h, required 1001 dat 0", {tx_o, wb_ack_o, wb_err_o, irq_o}, wb_dat_o);
    end
    rst_ni = 1'b1;
    wb_access(1'b0, UART_REG_STATUS, '0, ack, err, rd);
    n_cmp++;
    if (ack !== 1'b1 || rd !== 64'h1) begin
      n_fail++;
      $display("FAIL reset_status: ack %0b data 0x%0h, required ack 1 data 0x1", ack, rd);
    end
    wb_access(1'b0, UART_REG_DIVISOR, '0, ack, err, rd);
    n_cmp++;
    if (ack !== 1'b1 || rd !== 64'd868) begin
      n_fail++;
      $display("FAIL reset_divisor: data %0d, required 868", rd);
    end
    wb_access(1'b0, UART_REG_CTRL, '0, ack, err, rd);
    n_cmp++;
    if (rd !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_ctrl: data 0x%0h, required 0x0", rd);
    end
    wb_access(1'b0, UART_REG_DATA, '0, ack, err, rd);
    n_cmp++;
    if (ack !== 1'b1 || rd !== 64'h0) begin
      n_fail++;
      $display("FAIL data_read: ack %0b data 0x%0h, required ack 1 data 0x0", ack, rd);
    end
    wb_access(1'b1, UART_REG_STATUS, 64'hFF, ack, err, rd);
    n_cmp++;
    if ({ack, err} !== 2'b10) begin
      n_fail++;
      $display("FAIL status_write: ack/err %b, required 10", {ack, err});
    end
  endtask

  task automatic test_basic_frame();
    logic ack, err;
    logic [DW-1:0] rd;
    wb_access(1'b1, UART_REG_DIVISOR, 64'd0, ack, err, rd);
    wb_access(1'b0, UART_REG_DIVISOR, '0, ack, err, rd);
    n_cmp++;
    if (rd !== 64'd1) begin
      n_fail++;
      $display("FAIL divisor_zero: read %0d, required 1", rd);
    end
    wb_access(1'b1, UART_REG_DIVISOR, 64'd4, ack, err, rd);
    div_cur = 4;
    push_byte(8'h55, 1'b1, 1'b0, ack, err);
    n_cmp++;
    if ({ack, err} !== 2'b10) begin
      n_fail++;
      $display("FAIL push_55: ack/err %b, required 10", {ack, err});
    end
    @(posedge clk); #1;
    n_cmp++;
    if (tx_o !== 1'b1) begin
      n_fail++;
      $display("FAIL start_latency_1: tx %b one edge after ack, required 1", tx_o);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (tx_o !== 1'b0) begin
      n_fail++;
      $display("FAIL start_latency_2: tx %b two edges after ack, required 0", tx_o);
    end
    wait_idle(200, "basic");
    wb_access(1'b0, UART_REG_STATUS, '0, ack, err, rd);
    n_cmp++;
    if (rd !== 64'h1) begin
      n_fail++;
      $display("FAIL basic_status: 0x%0h, required 0x1 (empty, not busy)", rd);
    end
  endtask

  task automatic test_back_to_back();
    logic ack, err;
    logic [DW-1:0] rd;
    wb_access(1'b1, UART_REG_DIVISOR, 64'd2, ack, err, rd);
    div_cur = 2;
    starts.delete();
    push_byte(8'hA5, 1'b1, 1'b0, ack, err);
    push_byte(8'h3C, 1'b1, 1'b0, ack, err);
    wait_idle(200, "b2b");
    n_cmp++;
    if (starts.size() != 2 || starts[1] - starts[0] != 20) begin
      n_fail++;
      $display("FAIL b2b_gap: %0d frames, start spacing %0d cycles, required 2 frames spaced 20",
               starts.size(), (starts.size() == 2) ? starts[1] - starts[0] : -1);
    end
  endtask

  task automatic test_div_change();
    logic ack, err;
    logic [DW-1:0] rd;
    wb_access(1'b1, UART_REG_DIVISOR, 64'd4, ack, err, rd);
    div_cur = 4;
    starts.delete();
    push_byte(8'h96, 1'b1, 1'b0, ack, err);
    repeat (15) @(negedge clk);
    wb_access(1'b1, UART_REG_DIVISOR, 64'd8, ack, err, rd);
    div_cur = 8;
    push_byte(8'h4B, 1'b1, 1'b0, ack, err);
    wait_idle(400, "divchg");
    n_cmp++;
    if (starts.size() != 2 || starts[1] - starts[0] != 40) begin
      n_fail++;
      $display("FAIL divchg_len: %0d frames, first frame %0d cycles, required 2 frames, first 40",
               starts.size(), (starts.size() == 2) ? starts[1] - starts[0] : -1);
    end
  endtask

  task automatic test_parity();
    logic ack, err;
    logic [DW-1:0] rd;
    wb_access(1'b1, UART_REG_DIVISOR, 64'd4, ack, err, rd);
    div_cur = 4;
    wb_access(1'b1, UART_REG_CTRL, 64'h300, ack, err, rd);
    par_en_cur = PAR_IMPL;
    wb_access(1'b0, UART_REG_CTRL, '0, ack, err, rd);
    n_cmp++;
    if (rd !== (PAR_IMPL ? 64'h300 : 64'h000)) begin
      n_fail++;
      $display("FAIL ctrl_readback: 0x%0h, required 0x%0h", rd, PAR_IMPL ? 64'h300 : 64'h000);
    end
    push_byte(8'h07, 1'b1, 1'b0, ack, err);
    wait_idle(200, "par_odd");
    wb_access(1'b1, UART_REG_CTRL, 64'h100, ack, err, rd);
    push_byte(8'h07, 1'b1, 1'b1, ack, err);
    wait_idle(200, "par_even");
    wb_access(1'b1, UART_REG_CTRL, 64'h0, ack, err, rd);
    par_en_cur = 1'b0;
  endtask

  task automatic test_fifo_full();
    logic ack, err;
    logic [DW-1:0] rd;
    wb_access(1'b1, UART_REG_DIVISOR, 64'hFFFF, ack, err, rd);
    div_cur = 65535;
    for (int i = 0; i < 18; i++) begin
      push_byte(8'(i + 1), i < 17, 1'b0, ack, err);
      n_cmp++;
      if ({ack, err} !== ((i < 17) ? 2'b10 : 2'b01)) begin
        n_fail++;
        $display("FAIL fill_write_%0d: ack/err %b, required %b", i + 1, {ack, err}, (i < 17) ? 2'b10 : 2'b01);
      end
    end
    wb_access(1'b0, UART_REG_STATUS, '0, ack, err, rd);
    n_cmp++;
    if (rd !== 64'h1006) begin
      n_fail++;
      $display("FAIL full_status: 0x%0h, required 0x1006", rd);
    end
    n_cmp++;
    if (irq_o !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_full_thresh0: %b, required 0", irq_o);
    end
    wb_access(1'b1, UART_REG_CTRL, 64'h10, ack, err, rd);
    @(posedge clk); #1;
    n_cmp++;
    if (irq_o !== 1'b1) begin
      n_fail++;
      $display("FAIL irq_level_eq_thresh: %b, required 1", irq_o);
    end
    wb_access(1'b1, UART_REG_CTRL, 64'h0F, ack, err, rd);
    @(posedge clk); #1;
    n_cmp++;
    if (irq_o !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_level_above_thresh: %b, required 0", irq_o);
    end
    pulse_reset();
  endtask

  task automatic test_reset_mid_frame();
    logic ack, err;
    logic [DW-1:0] rd;
    int n = 0;
    wb_access(1'b1, UART_REG_DIVISOR, 64'd4, ack, err, rd);
    div_cur = 4;
    push_byte(8'h00, 1'b1, 1'b0, ack, err);
    push_byte(8'h11, 1'b1, 1'b0, ack, err);
    while (tx_o !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (12) @(negedge clk);
    n_cmp++;
    if (tx_o !== 1'b0) begin
      n_fail++;
      $display("FAIL pre_reset_tx: %b mid data bits of 0x00, required 0", tx_o);
    end
    #1;
    rst_ni = 1'b0;
    exp_q.delete();
    #1;
    n_cmp++;
    if (tx_o !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset_tx: %b, required 1", tx_o);
    end
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    div_cur = 868;
    wb_access(1'b0, UART_REG_STATUS, '0, ack, err, rd);
    n_cmp++;
    if (rd !== 64'h1) begin
      n_fail++;
      $display("FAIL post_reset_status: 0x%0h, required 0x1", rd);
    end
    n_cmp++;
    if (irq_o !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_irq: %b, required 1", irq_o);
    end
    repeat (60) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_back_to_back();
    test_div_change();
    test_parity();
    test_fifo_full();
    test_reset_mid_frame();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover_frames: %0d expected frames never seen, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
